// File: rtl/raw_issue_queue.sv
// In-order issue queue that holds the head instruction until a read-after-write
// checker reports that its source entry has no pending writer.
module raw_issue_queue #(
  parameter int entry_num_bits = 4,
  parameter int depth_bits     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [entry_num_bits-1:0] in_src_num,
  input  logic [entry_num_bits-1:0] in_dst_num,
  input  logic                      in_dst_vld,
  output logic                      search_vld,
  output logic [entry_num_bits-1:0] search_num,
  input  logic                      raw_hit,
  output logic                      issue_vld,
  input  logic                      issue_rdy,
  output logic [entry_num_bits-1:0] issue_src,
  output logic [entry_num_bits-1:0] issue_dst,
  output logic                      add_vld,
  output logic [entry_num_bits-1:0] add_num,
  input  logic                      wb_vld,
  input  logic [entry_num_bits-1:0] wb_num,
  output logic                      minus_vld,
  output logic [entry_num_bits-1:0] minus_num,
  output logic [7:0]                stall_cnt,
  output logic [depth_bits:0]       count,
  output logic [1:0]                dbg_state
);

  localparam int depth = 1 << depth_bits;
  localparam logic [depth_bits:0] DEPTH_CNT = (depth_bits + 1)'(depth);
  localparam logic [depth_bits:0] ONE_CNT   = (depth_bits + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    WAIT   = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  // Handshakes: a transfer happens in a cycle where both vld and rdy are high;
  // a vld output, once raised, keeps its payload stable until its rdy is seen.
  state_t                    state_q, state_d;
  logic [entry_num_bits-1:0] src_mem_q [depth];
  logic [entry_num_bits-1:0] dst_mem_q [depth];
  logic [depth-1:0]          dv_mem_q;
  logic [depth_bits-1:0]     wr_ptr_q, rd_ptr_q;
  logic [depth_bits:0]       count_q, count_d;
  logic                      hit_seen_q, hit_seen_d;
  logic [7:0]                stall_q, stall_d;
  logic                      minus_vld_q;
  logic [entry_num_bits-1:0] minus_num_q;

  logic                      push, pop;
  logic [entry_num_bits-1:0] head_src, head_dst;
  logic                      head_dv;

  assign head_src = src_mem_q[rd_ptr_q];
  assign head_dst = dst_mem_q[rd_ptr_q];
  assign head_dv  = dv_mem_q[rd_ptr_q];

  // in_rdy looks only at the registered count, so a full queue never accepts
  // even when the head leaves in the same cycle.
  assign in_rdy = (count_q < DEPTH_CNT);
  assign push   = in_vld && in_rdy;
  assign pop    = (state_q == ISSUE) && issue_rdy;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    search_vld = 1'b0;
    search_num = '0;
    issue_vld  = 1'b0;
    issue_src  = '0;
    issue_dst  = '0;
    add_vld    = 1'b0;
    add_num    = '0;
    case (state_q)
      IDLE: begin
        if (count_d != '0) state_d = SEARCH;
      end
      SEARCH: begin
        search_vld = 1'b1;
        search_num = head_src;
        state_d    = WAIT;
      end
      WAIT: begin
        state_d = raw_hit ? SEARCH : ISSUE;
      end
      ISSUE: begin
        issue_vld = 1'b1;
        issue_src = head_src;
        issue_dst = head_dst;
        if (issue_rdy) begin
          add_vld = head_dv;
          add_num = head_dv ? head_dst : '0;
          state_d = (count_d != '0) ? SEARCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // After the first hit, every lookup-loop cycle that keeps the head blocked
  // counts; the final miss cycle does not, so n hits give 2n-1.
  always_comb begin
    hit_seen_d = hit_seen_q;
    stall_d    = stall_q;
    if (pop) begin
      hit_seen_d = 1'b0;
      stall_d    = '0;
    end else begin
      if ((state_q == WAIT) && raw_hit) hit_seen_d = 1'b1;
      if (hit_seen_q && stall_q != 8'hff &&
          ((state_q == SEARCH) || ((state_q == WAIT) && raw_hit)))
        stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hit_seen_q  <= 1'b0;
      stall_q     <= '0;
      minus_vld_q <= 1'b0;
      minus_num_q <= '0;
      dv_mem_q    <= '0;
      for (int i = 0; i < depth; i++) begin
        src_mem_q[i] <= '0;
        dst_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hit_seen_q  <= hit_seen_d;
      stall_q     <= stall_d;
      minus_vld_q <= wb_vld;
      minus_num_q <= wb_num;
      if (push) begin
        src_mem_q[wr_ptr_q] <= in_src_num;
        dst_mem_q[wr_ptr_q] <= in_dst_num;
        dv_mem_q[wr_ptr_q]  <= in_dst_vld;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign minus_vld = minus_vld_q;
  assign minus_num = minus_num_q;
  assign stall_cnt = stall_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: doc/raw_issue_queue.md
RAW_ISSUE_QUEUE -- requirements
Module: raw_issue_queue

Interface
REQ-001 Parameter entry_num_bits, default 4, width of a register/entry number.
REQ-002 Parameter depth_bits, default 2, queue depth = 1 << depth_bits (4).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_vld  input  1  upstream offers an instruction.
REQ-006 in_rdy  output  1  queue accepts; high iff count < depth.
REQ-007 in_src_num  input  entry_num_bits  source entry read by the instruction.
REQ-008 in_dst_num  input  entry_num_bits  destination entry written.
REQ-009 in_dst_vld  input  1  instruction writes in_dst_num.
REQ-010 search_vld  output  1  hazard lookup request to the RAW checker.
REQ-011 search_num  output  entry_num_bits  head source entry being looked up.
REQ-012 raw_hit  input  1  checker result, valid the cycle after search_vld.
REQ-013 issue_vld / issue_rdy  output / input  1 / 1  downstream issue handshake.
REQ-014 issue_src, issue_dst  output  entry_num_bits each  head instruction fields.
REQ-015 add_vld, add_num  output  1, entry_num_bits  increment pending-writer count.
REQ-016 wb_vld, wb_num  input  1, entry_num_bits  writeback completion.
REQ-017 minus_vld, minus_num  output  1, entry_num_bits  decrement pending-writer count.
REQ-018 stall_cnt  output  8  cycles current head has been blocked.
REQ-019 count  output  depth_bits+1  occupancy, 0..depth.

Function
REQ-020 In-order circular FIFO; push when in_vld && in_rdy; pop on issue handshake (issue_vld && issue_rdy).
REQ-021 No pass-through: when full, in_rdy = 0 even if a pop occurs that cycle.
REQ-022 Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo depth.
REQ-023 FSM states IDLE, SEARCH, WAIT, ISSUE.
REQ-024 IDLE: all handshake outputs low; -> SEARCH when count != 0.
REQ-025 SEARCH: search_vld = 1 one cycle, search_num = head src; -> WAIT.
REQ-026 WAIT: sample raw_hit; hit -> SEARCH (re-check), no hit -> ISSUE.
REQ-027 ISSUE: issue_vld = 1, fields = head; hold stable until issue_rdy.
REQ-028 On issue handshake: pop; -> SEARCH if count after pop != 0, else IDLE.
REQ-029 add_vld = 1 for exactly the handshake cycle iff head dst_vld; add_num = head dst.
REQ-030 Minimum latency empty push -> issue_vld: 3 cycles (push cycle N, search N+1, wait N+2, issue N+3).
REQ-031 minus_vld/minus_num = wb_vld/wb_num registered one cycle; independent of FSM.
REQ-032 stall_cnt: +1 every cycle in SEARCH or WAIT after the first hit for the current head; saturates at 255; cleared to 0 on issue handshake.
REQ-033 Hazard caused by an add in the same cycle as a search: checker result governs; queue does not re-order.
REQ-034 count, pointers never exceed depth; push when full ignored.

Reset
REQ-035 rst high at posedge: state IDLE, count 0, pointers 0, stall_cnt 0, all vld outputs 0, search_num/issue_src/issue_dst/add_num/minus_num 0.
REQ-036 rst mid-operation discards queued instructions and pending wb register; in_rdy = 1 the cycle after rst deasserts.

Verification
REQ-037 Push src=3,dst=5,dst_vld=1 into empty queue, raw_hit=0, issue_rdy=1 -> search_num=3 at N+1, issue_vld at N+3, add_vld=1 add_num=5 that cycle, count 0 after.
REQ-038 Head src=7, raw_hit=1 for 3 lookups then 0 -> three extra SEARCH/WAIT loops, stall_cnt reaches 5 then clears on issue.
REQ-039 Push 5 instructions back-to-back, issue_rdy=0 -> in_rdy falls after 4th, count=4, 5th not accepted; release issue_rdy -> 4 issues in push order.
REQ-040 Full queue, push and pop same cycle -> push rejected, count 3; with count 2 push+pop -> count 2, pointers wrap correctly after 8 operations.
REQ-041 wb_vld=1 wb_num=9 at N -> minus_vld=1 minus_num=9 at N+1, regardless of FSM state.
REQ-042 rst asserted while in ISSUE with count 3 -> next cycle IDLE, count 0, issue_vld 0, stall_cnt 0.
